// File: rtl/bias_sched_pkg.sv
// Shared types and defaults for the bias scheduler and its read pipeline.
package bias_sched_pkg;

    localparam int BIAS_CORE       = 8;
    localparam int BIAS_RD_LAT_DEF = 2;

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        WAIT,
        RUN,
        NEXT,
        DONE
    } bias_sched_state_t;

    function automatic logic [31:0] sat_inc32(input logic [31:0] v);
        return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
    endfunction

endpackage

// File: rtl/bias_rd_pipe.sv
// Delays a read-valid and lane index by the memory latency and decodes
// the result into a one-hot register write strobe.
module bias_rd_pipe #(
    parameter int DEPTH = 2,
    parameter int CORE  = 8,
    parameter int LW    = 3
) (
    input  logic            clk,
    input  logic            xrst,
    input  logic            i_valid,
    input  logic [LW-1:0]   i_lane,
    output logic            o_valid,
    output logic [LW-1:0]   o_lane,
    output logic [CORE-1:0] o_we
);

    logic [DEPTH-1:0] r_vld;
    logic [LW-1:0]    r_lane [DEPTH];

    always_ff @(posedge clk or negedge xrst) begin
        if (!xrst) begin
            r_vld <= '0;
            for (int i = 0; i < DEPTH; i++) r_lane[i] <= '0;
        end else begin
            r_vld[0]  <= i_valid;
            r_lane[0] <= i_lane;
            for (int i = 1; i < DEPTH; i++) begin
                r_vld[i]  <= r_vld[i-1];
                r_lane[i] <= r_lane[i-1];
            end
        end
    end

    assign o_valid = r_vld[DEPTH-1];
    assign o_lane  = r_lane[DEPTH-1];

    genvar gi;
    generate
        for (gi = 0; gi < CORE; gi++) begin : g_we
            assign o_we[gi] = r_vld[DEPTH-1] && (r_lane[DEPTH-1] == LW'(gi));
        end
    endgenerate

endmodule

// File: rtl/bias_sched.sv
// Per-layer bias loader: fetches CORE biases per channel group, then gates the
// ctrl stream into the bias stage. Define BIAS_SCHED_PERF_EN to add stall_cnt.
module bias_sched
    import bias_sched_pkg::*;
#(
    parameter int CORE   = BIAS_CORE,
    parameter int BWIDTH = 16,
    parameter int AWIDTH = 12,
    parameter int NWIDTH = 10,
    parameter int RD_LAT = BIAS_RD_LAT_DEF
) (
    input  logic              clk,
    input  logic              xrst,
    input  logic              req,
    input  logic [NWIDTH-1:0] n_out,
    input  logic [AWIDTH-1:0] base_addr,
    output logic              mem_re,
    output logic [AWIDTH-1:0] mem_addr,
    input  logic [BWIDTH-1:0] mem_rdata,
    output logic [CORE-1:0]   bias_we,
    output logic [BWIDTH-1:0] bias_wdata,
    input  logic              in_start,
    input  logic              in_valid,
    input  logic              in_stop,
    output logic              out_start,
    output logic              out_valid,
    output logic              out_stop,
    output logic              busy,
    output logic              ack,
    output logic              err
`ifdef BIAS_SCHED_PERF_EN
    ,
    output logic [31:0]       stall_cnt
`endif
);

    localparam int LW = (CORE > 1) ? $clog2(CORE) : 1;
    // One extra bit so grp_base+CORE cannot overflow near the top of n_out.
    localparam int GW = NWIDTH + 1;

    bias_sched_state_t r_state;
    logic [NWIDTH-1:0] r_n;
    logic [AWIDTH-1:0] r_base;
    logic [GW-1:0]     r_grp;
    logic [LW-1:0]     r_lane;
    logic [LW-1:0]     r_last;
    logic              r_mem_re;
    logic [AWIDTH-1:0] r_mem_addr;
    logic              r_out_start;
    logic              r_out_valid;
    logic              r_out_stop;
    logic              r_busy;
    logic              r_ack;
    logic              r_err;

    logic [GW-1:0]     w_grp_nxt;
    logic              w_pipe_valid;
    logic [LW-1:0]     w_pipe_lane;
    logic [CORE-1:0]   w_pipe_we;

    function automatic logic [LW-1:0] f_last(input logic [GW-1:0] rem);
        return (rem >= GW'(CORE)) ? LW'(CORE - 1) : LW'(rem - GW'(1));
    endfunction

    assign w_grp_nxt = r_grp + GW'(CORE);

    always_ff @(posedge clk or negedge xrst) begin
        if (!xrst) begin
            r_state     <= IDLE;
            r_n         <= '0;
            r_base      <= '0;
            r_grp       <= '0;
            r_lane      <= '0;
            r_last      <= '0;
            r_mem_re    <= 1'b0;
            r_mem_addr  <= '0;
            r_out_start <= 1'b0;
            r_out_valid <= 1'b0;
            r_out_stop  <= 1'b0;
            r_busy      <= 1'b0;
            r_ack       <= 1'b0;
            r_err       <= 1'b0;
        end else begin
            r_ack       <= 1'b0;
            r_out_start <= (r_state == RUN) && in_start;
            r_out_valid <= (r_state == RUN) && in_valid;
            r_out_stop  <= (r_state == RUN) && in_stop;
            if ((r_state != RUN) && (in_start || in_valid || in_stop))
                r_err <= 1'b1;

            case (r_state)
                IDLE: begin
                    if (req) begin
                        r_n    <= n_out;
                        r_base <= base_addr;
                        r_grp  <= '0;
                        r_busy <= 1'b1;
                        if (n_out == '0) begin
                            r_state <= DONE;
                        end else begin
                            r_state    <= FETCH;
                            r_mem_re   <= 1'b1;
                            r_mem_addr <= base_addr;
                            r_lane     <= '0;
                            r_last     <= f_last(GW'(n_out));
                        end
                    end
                end
                FETCH: begin
                    if (r_lane == r_last) begin
                        r_mem_re <= 1'b0;
                        r_state  <= WAIT;
                    end else begin
                        r_lane     <= r_lane + LW'(1);
                        r_mem_addr <= r_mem_addr + AWIDTH'(1);
                    end
                end
                WAIT: begin
                    if (w_pipe_valid && (w_pipe_lane == r_last))
                        r_state <= RUN;
                end
                RUN: begin
                    if (in_stop)
                        r_state <= NEXT;
                end
                NEXT: begin
                    r_grp <= w_grp_nxt;
                    if (w_grp_nxt >= GW'(r_n)) begin
                        r_state <= DONE;
                    end else begin
                        r_state    <= FETCH;
                        r_mem_re   <= 1'b1;
                        r_mem_addr <= r_base + AWIDTH'(w_grp_nxt);
                        r_lane     <= '0;
                        r_last     <= f_last(GW'(r_n) - w_grp_nxt);
                    end
                end
                DONE: begin
                    r_ack   <= 1'b1;
                    r_busy  <= 1'b0;
                    r_state <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    bias_rd_pipe #(
        .DEPTH (RD_LAT),
        .CORE  (CORE),
        .LW    (LW)
    ) u_rd_pipe (
        .clk     (clk),
        .xrst    (xrst),
        .i_valid (r_mem_re),
        .i_lane  (r_lane),
        .o_valid (w_pipe_valid),
        .o_lane  (w_pipe_lane),
        .o_we    (w_pipe_we)
    );

    assign mem_re     = r_mem_re;
    assign mem_addr   = r_mem_addr;
    assign bias_we    = w_pipe_we;
    // Read data is only meaningful on write cycles; keep the bus quiet otherwise.
    assign bias_wdata = w_pipe_valid ? mem_rdata : '0;
    assign out_start  = r_out_start;
    assign out_valid  = r_out_valid;
    assign out_stop   = r_out_stop;
    assign busy       = r_busy;
    assign ack        = r_ack;
    assign err        = r_err;

`ifdef BIAS_SCHED_PERF_EN
    logic [31:0] r_stall_cnt;

    always_ff @(posedge clk or negedge xrst) begin
        if (!xrst) begin
            r_stall_cnt <= '0;
        end else if ((r_state == IDLE) && req) begin
            r_stall_cnt <= '0;
        end else if (r_busy && ((r_state == FETCH) || (r_state == WAIT) || (r_state == NEXT))) begin
            r_stall_cnt <= sat_inc32(r_stall_cnt);
        end
    end

    assign stall_cnt = r_stall_cnt;
`endif

endmodule

// File: tb/tb_bias_sched.sv
// Directed self-checking bench for bias_sched (CORE=8, RD_LAT=2) with a
// behavioural bias memory of fixed read latency.
module tb_bias_sched;

    localparam int RDL = 2;

    logic        clk = 1'b0;
    logic        xrst = 1'b0;
    logic        req = 1'b0;
    logic [9:0]  n_out = '0;
    logic [11:0] base_addr = '0;
    logic        mem_re;
    logic [11:0] mem_addr;
    logic [15:0] mem_rdata;
    logic [7:0]  bias_we;
    logic [15:0] bias_wdata;
    logic        in_start = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_stop = 1'b0;
    logic        out_start, out_valid, out_stop;
    logic        busy, ack, err;
`ifdef BIAS_SCHED_PERF_EN
    logic [31:0] stall_cnt;
`endif

    int n_chk = 0;
    int n_fail = 0;
    logic exp_err = 1'b0;

    always #5 clk = ~clk;

    bias_sched dut (
        .clk        (clk),
        .xrst       (xrst),
        .req        (req),
        .n_out      (n_out),
        .base_addr  (base_addr),
        .mem_re     (mem_re),
        .mem_addr   (mem_addr),
        .mem_rdata  (mem_rdata),
        .bias_we    (bias_we),
        .bias_wdata (bias_wdata),
        .in_start   (in_start),
        .in_valid   (in_valid),
        .in_stop    (in_stop),
        .out_start  (out_start),
        .out_valid  (out_valid),
        .out_stop   (out_stop),
        .busy       (busy),
        .ack        (ack),
        .err        (err)
`ifdef BIAS_SCHED_PERF_EN
        ,
        .stall_cnt  (stall_cnt)
`endif
    );

    function automatic logic [15:0] memval(input logic [11:0] a);
        return 16'h5A00 ^ {a, 4'h3};
    endfunction

    // Two-stage read pipeline: data for a read in cycle t is on the bus in cycle t+2.
    logic [15:0] rd1, rd2;
    always @(posedge clk) begin
        rd1 <= mem_re ? memval(mem_addr) : 16'hDEAD;
        rd2 <= rd1;
    end
    assign mem_rdata = rd2;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_chk++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    task automatic start_layer(input logic [9:0] n, input logic [11:0] base);
        req = 1'b1;
        n_out = n;
        base_addr = base;
        @(negedge clk);
        req = 1'b0;
        n_out = 10'h3FF;
        base_addr = 12'h000;
    endtask

    task automatic fetch_group(input logic [11:0] base, input int L, input bit stray);
        logic [7:0] we_e;
        for (int i = 0; i < L + RDL; i++) begin
            we_e = '0;
            if (i >= RDL) we_e[i-RDL] = 1'b1;
            chk("fetch_re", {31'd0, mem_re}, {31'd0, (i < L)});
            if (i < L) chk("fetch_addr", {20'd0, mem_addr}, {20'd0, base + 12'(i)});
            chk("fetch_we", {24'd0, bias_we}, {24'd0, we_e});
            if (i >= RDL)
                chk("fetch_wdata", {16'd0, bias_wdata}, {16'd0, memval(base + 12'(i - RDL))});
            chk("fetch_gate", {29'd0, out_start, out_valid, out_stop}, 32'd0);
            chk("fetch_err", {31'd0, err}, {31'd0, exp_err});
            chk("fetch_busy", {31'd0, busy}, 32'd1);
            in_valid = stray && (i == 0);
            @(negedge clk);
            if (stray && (i == 0)) exp_err = 1'b1;
        end
        in_valid = 1'b0;
    endtask

    task automatic run_stream(input int nb);
        logic [2:0] cur;
        chk("run_first_out", {29'd0, out_start, out_valid, out_stop}, 32'd0);
        chk("run_no_we", {24'd0, bias_we}, 32'd0);
        for (int b = 0; b < nb; b++) begin
            cur = {(b == 0), 1'b1, (b == nb - 1)};
            {in_start, in_valid, in_stop} = cur;
            @(negedge clk);
            chk("run_out", {29'd0, out_start, out_valid, out_stop}, {29'd0, cur});
        end
        {in_start, in_valid, in_stop} = 3'b000;
        chk("run_err", {31'd0, err}, {31'd0, exp_err});
    endtask

    // Entered at the negedge of the DONE cycle; probes that req there is ignored.
    task automatic finish_layer();
        chk("done_ack", {31'd0, ack}, 32'd0);
        chk("done_busy", {31'd0, busy}, 32'd1);
        chk("done_re", {31'd0, mem_re}, 32'd0);
        req = 1'b1;
        @(negedge clk);
        req = 1'b0;
        chk("ack_pulse", {31'd0, ack}, 32'd1);
        chk("ack_busy", {31'd0, busy}, 32'd0);
        @(negedge clk);
        chk("ack_end", {31'd0, ack}, 32'd0);
        chk("post_busy", {31'd0, busy}, 32'd0);
        chk("post_re", {31'd0, mem_re}, 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(negedge clk);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_ack", {31'd0, ack}, 32'd0);
        chk("rst_err", {31'd0, err}, 32'd0);
        chk("rst_re", {31'd0, mem_re}, 32'd0);
        chk("rst_addr", {20'd0, mem_addr}, 32'd0);
        chk("rst_we", {24'd0, bias_we}, 32'd0);
        chk("rst_wdata", {16'd0, bias_wdata}, 32'd0);
        chk("rst_out", {29'd0, out_start, out_valid, out_stop}, 32'd0);
`ifdef BIAS_SCHED_PERF_EN
        chk("rst_stall", stall_cnt, 32'd0);
`endif
        xrst = 1'b1;
        @(negedge clk);

        // Basic single full group
        start_layer(10'd8, 12'h100);
        fetch_group(12'h100, 8, 1'b0);
        run_stream(4);
        @(negedge clk);
        finish_layer();
        $display("txn basic n_out=8 base=100 done, checks=%0d", n_chk);

        // Partial second group
        start_layer(10'd11, 12'h100);
        fetch_group(12'h100, 8, 1'b0);
        run_stream(3);
        @(negedge clk);
        fetch_group(12'h108, 3, 1'b0);
        run_stream(2);
        @(negedge clk);
        finish_layer();
        $display("txn partial n_out=11 done, checks=%0d", n_chk);

        // Empty layer: req -> DONE -> ack
        start_layer(10'd0, 12'h200);
        chk("zero_out", {29'd0, out_start, out_valid, out_stop}, 32'd0);
        finish_layer();
        $display("txn empty n_out=0 done, checks=%0d", n_chk);

        // Stray beat during FETCH sets sticky err, layer still completes
        start_layer(10'd8, 12'h200);
        fetch_group(12'h200, 8, 1'b1);
        run_stream(2);
        @(negedge clk);
        finish_layer();
        chk("err_sticky", {31'd0, err}, 32'd1);
        $display("txn stray n_out=8 done, checks=%0d", n_chk);

        // Asynchronous reset in the middle of RUN
        start_layer(10'd8, 12'h300);
        fetch_group(12'h300, 8, 1'b0);
        in_start = 1'b1;
        in_valid = 1'b1;
        @(negedge clk);
        chk("mid_out_valid", {31'd0, out_valid}, 32'd1);
        chk("mid_out_start", {31'd0, out_start}, 32'd1);
        in_start = 1'b0;
        #2 xrst = 1'b0;
        #1;
        exp_err = 1'b0;
        chk("arst_busy", {31'd0, busy}, 32'd0);
        chk("arst_out", {29'd0, out_start, out_valid, out_stop}, 32'd0);
        chk("arst_err", {31'd0, err}, 32'd0);
        chk("arst_re", {31'd0, mem_re}, 32'd0);
        chk("arst_we", {24'd0, bias_we}, 32'd0);
        in_valid = 1'b0;
        @(negedge clk);
        xrst = 1'b1;
        @(negedge clk);
        chk("arst_no_ack", {31'd0, ack}, 32'd0);
        chk("arst_idle_busy", {31'd0, busy}, 32'd0);
        $display("txn reset mid-RUN done, checks=%0d", n_chk);

        // Address wrap, start+stop in one beat
        start_layer(10'd4, 12'hFFE);
        fetch_group(12'hFFE, 4, 1'b0);
        run_stream(1);
        @(negedge clk);
        finish_layer();
`ifdef BIAS_SCHED_PERF_EN
        chk("stall_cnt", stall_cnt, 32'd7);
`endif
        $display("txn wrap n_out=4 base=FFE done, checks=%0d", n_chk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
